argmax_stream: RTL



---
 rtl/argmax_pkg.sv | 17 +
 rtl/lane_argmax.sv | 55 +++++
 rtl/argmax_stream.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/argmax_pkg.sv
// Shared constants and types for the streaming argmax block.
// Provides the default score width, class count, lane count and index width,
// plus the two-state frame FSM encoding used by argmax_stream.
package argmax_pkg;

   localparam int unsigned DefBitWidth   = 8;
   localparam int unsigned DefNumClasses = 10;
   localparam int unsigned DefLanes      = 2;
   localparam int unsigned DefIndexWidth = 4;

   // StAccum: collecting beats of a frame. StHold: result presented, input stalled.
   typedef enum logic [0:0] {
      StAccum,
      StHold
   } argmax_state_e;

endpackage

// File: rtl/lane_argmax.sv
// Combinational signed maximum across the LANES scores of one input beat.
// Built as a binary tree of two-input compares; the lower-lane input wins ties.
// Ports:
//   data_i      packed scores, lane k at bits [BIT_WIDTH*(k+1)-1 : BIT_WIDTH*k]
//   max_val_o   largest score (signed)
//   max_lane_o  lane holding that score (lowest lane on a tie)
module lane_argmax #(
   parameter int unsigned BIT_WIDTH = 8,
   parameter int unsigned LANES     = 2,
   parameter int unsigned LANE_W    = 1
) (
   input  logic [BIT_WIDTH*LANES-1:0] data_i,
   output logic [BIT_WIDTH-1:0]       max_val_o,
   output logic [LANE_W-1:0]          max_lane_o
);

   // Pad the leaf level to a power of two; padding leaves are marked invalid.
   localparam int unsigned NumLeaves = (LANES > 1) ? (1 << $clog2(LANES)) : 1;
   localparam int unsigned NumNodes  = 2 * NumLeaves - 1;

   logic [BIT_WIDTH-1:0] node_val  [NumNodes];
   logic [LANE_W-1:0]    node_lane [NumNodes];
   logic                 node_vld  [NumNodes];

   always_comb begin
      for (int n = 0; n < int'(NumNodes); n++) begin
         node_val[n]  = '0;
         node_lane[n] = '0;
         node_vld[n]  = 1'b0;
      end
      for (int k = 0; k < int'(LANES); k++) begin
         node_val[int'(NumLeaves) - 1 + k]  = data_i[BIT_WIDTH*k +: BIT_WIDTH];
         node_lane[int'(NumLeaves) - 1 + k] = LANE_W'(k);
         node_vld[int'(NumLeaves) - 1 + k]  = 1'b1;
      end
      // Children of node n are 2n+1 (lower lanes) and 2n+2 (higher lanes);
      // the higher side wins only when strictly greater.
      for (int n = int'(NumLeaves) - 2; n >= 0; n--) begin
         if (node_vld[2*n+2] &&
             (!node_vld[2*n+1] ||
              ($signed(node_val[2*n+2]) > $signed(node_val[2*n+1])))) begin
            node_val[n]  = node_val[2*n+2];
            node_lane[n] = node_lane[2*n+2];
         end else begin
            node_val[n]  = node_val[2*n+1];
            node_lane[n] = node_lane[2*n+1];
         end
         node_vld[n] = node_vld[2*n+1] | node_vld[2*n+2];
      end
   end

   assign max_val_o  = node_val[0];
   assign max_lane_o = node_lane[0];

endmodule

// File: rtl/argmax_stream.sv
// Streaming argmax over one frame of NUM_CLASSES signed scores, LANES per beat.
// The running maximum and its class index are tracked across the frame; the
// result is then held on the output handshake while input is stalled.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid/in_ready    input beat handshake, in_data packed LANES scores
//   out_valid/out_ready  result handshake, out_idx winning class, out_val its score
//   in_last/err_last     only with ARGMAX_LAST_CHECK_EN: frame delimiter from the
//                        producer, and a flag that it disagreed with the count
module argmax_stream
   import argmax_pkg::*;
#(
   parameter int unsigned BIT_WIDTH   = DefBitWidth,
   parameter int unsigned NUM_CLASSES = DefNumClasses,
   parameter int unsigned LANES       = DefLanes,
   parameter int unsigned INDEX_WIDTH = DefIndexWidth
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [BIT_WIDTH*LANES-1:0] in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [INDEX_WIDTH-1:0]     out_idx,
   output logic [BIT_WIDTH-1:0]       out_val
`ifdef ARGMAX_LAST_CHECK_EN
   ,
   input  logic                       in_last,
   output logic                       err_last
`endif
);

   localparam int unsigned LaneW    = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int unsigned NumBeats = NUM_CLASSES / LANES;
   localparam int unsigned BeatW    = (NumBeats > 1) ? $clog2(NumBeats) : 1;

   argmax_state_e          state_q, state_d;
   logic [BeatW-1:0]       beat_q, beat_d;
   logic [BIT_WIDTH-1:0]   max_q, max_d;
   logic [INDEX_WIDTH-1:0] idx_q, idx_d;

   logic [BIT_WIDTH-1:0]   best_val;
   logic [LaneW-1:0]       best_lane;
   logic [INDEX_WIDTH-1:0] cand_idx;
   logic                   in_fire;
   logic                   final_beat;
   logic                   frame_end;

   lane_argmax #(
      .BIT_WIDTH (BIT_WIDTH),
      .LANES     (LANES),
      .LANE_W    (LaneW)
   ) u_lane_argmax (
      .data_i     (in_data),
      .max_val_o  (best_val),
      .max_lane_o (best_lane)
   );

   assign in_ready   = (state_q == StAccum);
   assign out_valid  = (state_q == StHold);
   assign out_idx    = idx_q;
   assign out_val    = max_q;
   assign in_fire    = in_valid && in_ready;
   assign final_beat = (beat_q == BeatW'(NumBeats - 1));
   assign cand_idx   = INDEX_WIDTH'(beat_q) * INDEX_WIDTH'(LANES) + INDEX_WIDTH'(best_lane);

`ifdef ARGMAX_LAST_CHECK_EN
   logic err_q, err_d;
   logic frame_err;

   // Either marker ends the frame; they must agree or the result is flagged.
   assign frame_end = final_beat || in_last;
   assign frame_err = final_beat != in_last;
   assign err_last  = err_q;

   always_comb begin
      err_d = err_q;
      if (in_fire && frame_end) begin
         err_d = frame_err;
      end else if (out_valid && out_ready) begin
         err_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end
`else
   assign frame_end = final_beat;
`endif

   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      max_d   = max_q;
      idx_d   = idx_q;
      unique case (state_q)
         StAccum: begin
            if (in_fire) begin
               // First beat always loads; later beats need a strictly larger score.
               if ((beat_q == '0) || ($signed(best_val) > $signed(max_q))) begin
                  max_d = best_val;
                  idx_d = cand_idx;
               end
               if (frame_end) begin
                  beat_d  = '0;
                  state_d = StHold;
               end else begin
                  beat_d = beat_q + 1'b1;
               end
            end
         end
         StHold: begin
            if (out_ready) begin
               state_d = StAccum;
            end
         end
         default: state_d = StAccum;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StAccum;
         beat_q  <= '0;
         max_q   <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         max_q   <= max_d;
         idx_q   <= idx_d;
      end
   end

endmodule
